// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and the IF/ID register, drives the code ROM address and
// handles stall, taken-branch flush and end-of-program detection.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 68,
  parameter logic [31:0] NOP_INST  = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_plus8_o,
  output logic        valid_o,
  output logic        done_o
);

  typedef enum logic {StRun, StEnd} state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
  localparam logic [32:0] MemLimit       = 33'(MEM_BYTES);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        valid_q;

  logic [31:0] target_aligned;
  logic [32:0] pc_last_byte;
  logic [32:0] target_last_byte;
  logic        pc_in_range;
  logic        target_in_range;
  logic        unused_target_bits;

  assign target_aligned   = {branch_target_i[31:2], 2'b00};
  assign unused_target_bits = ^branch_target_i[1:0];

  // 33-bit sums so an address near 2^32 never wraps back into range.
  assign pc_last_byte     = {1'b0, pc_q} + 33'd3;
  assign target_last_byte = {1'b0, target_aligned} + 33'd3;
  assign pc_in_range      = pc_last_byte < MemLimit;
  assign target_in_range  = target_last_byte < MemLimit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      pc_q      <= ResetPcAligned;
      inst_q    <= NOP_INST;
      inst_pc_q <= 32'h0;
      valid_q   <= 1'b0;
    end else if (branch_i) begin
      // Flush the wrong-path word; inst_pc keeps its last value.
      pc_q    <= target_aligned;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      state_q <= target_in_range ? StRun : StEnd;
    end else if (!stall_i) begin
      if (state_q == StRun && pc_in_range) begin
        inst_q    <= inst_i;
        inst_pc_q <= pc_q;
        valid_q   <= 1'b1;
        pc_q      <= pc_q + 32'd4;
      end else begin
        state_q <= StEnd;
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign inst_pc_o  = inst_pc_q;
  assign pc_plus8_o = inst_pc_q + 32'd8;
  assign valid_o    = valid_q;
  assign done_o     = (state_q == StEnd);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed plan checks with literal values, then random
// stall/branch/reset traffic compared every cycle against a behavioural model.
module tb_instr_fetch;

  localparam int unsigned MemBytes = 68;
  localparam logic [31:0] Nop      = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] pc_plus8_o;
  logic        valid_o;
  logic        done_o;

  logic [31:0] rom [0:31];

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state.
  longint m_pc;
  bit     m_done;
  logic [31:0] m_inst;
  longint m_ipc;
  bit     m_valid;

  instr_fetch #(
    .RESET_PC (32'h0),
    .MEM_BYTES(MemBytes),
    .NOP_INST (Nop)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .inst_i         (inst_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .pc_plus8_o     (pc_plus8_o),
    .valid_o        (valid_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // Combinational code ROM; out-of-range reads return a recognisable junk word.
  always_comb begin
    inst_i = 32'hBAD0_BAD0;
    if ({1'b0, pc_o} + 33'd3 < 33'(MemBytes)) inst_i = rom[pc_o[6:2]];
  end

  function automatic bit fits(input longint addr);
    return (addr + 3) < longint'(MemBytes);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_done = 0; m_inst = Nop; m_ipc = 0; m_valid = 0;
    end else if (branch_i) begin
      m_pc    = longint'(branch_target_i) / 4 * 4;
      m_inst  = Nop;
      m_valid = 0;
      m_done  = !fits(m_pc);
    end else if (!stall_i) begin
      if (!m_done && fits(m_pc)) begin
        m_inst  = rom[m_pc / 4];
        m_ipc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % (longint'(1) << 32);
      end else begin
        m_done  = 1;
        m_inst  = Nop;
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc_o",       pc_o,       32'(m_pc));
      chk("inst_o",     inst_o,     m_inst);
      chk("inst_pc_o",  inst_pc_o,  32'(m_ipc));
      chk("pc_plus8_o", pc_plus8_o, 32'(m_ipc + 8));
      chk("valid_o",    {31'b0, valid_o}, {31'b0, m_valid});
      chk("done_o",     {31'b0, done_o},  {31'b0, m_done});
    end
  end

  task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] tgt);
    reset = rst; stall_i = st; branch_i = br; branch_target_i = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_ipc;
    bit          hit_end;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    reset = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;

    step(1, 0, 0, 0);
    check_en = 1'b1;
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, Nop);
    chk("rst_ipc", inst_pc_o, 32'd0);
    chk("rst_pc8", pc_plus8_o, 32'd8);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);

    step(0, 0, 0, 0);
    chk("run1_pc", pc_o, 32'd4);
    chk("run1_ipc", inst_pc_o, 32'd0);
    chk("run1_valid", {31'b0, valid_o}, 32'd1);
    chk("run1_inst", inst_o, rom[0]);
    step(0, 0, 0, 0);
    chk("run2_pc", pc_o, 32'd8);
    chk("run2_ipc", inst_pc_o, 32'd4);
    chk("run2_pc8", pc_plus8_o, 32'd12);

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_pc", pc_o, 32'd8);
    chk("stall_ipc", inst_pc_o, 32'd4);
    chk("stall_inst", inst_o, rom[1]);
    step(0, 0, 0, 0);
    chk("unstall_pc", pc_o, 32'd12);
    chk("unstall_ipc", inst_pc_o, 32'd8);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_br_pc", pc_o, 32'd20);
    step(0, 0, 1, 32'h2F);
    chk("br_pc", pc_o, 32'h2C);
    chk("br_valid", {31'b0, valid_o}, 32'd0);
    chk("br_inst", inst_o, Nop);
    step(0, 0, 0, 0);
    chk("br_next_ipc", inst_pc_o, 32'h2C);
    chk("br_next_valid", {31'b0, valid_o}, 32'd1);

    step(0, 1, 1, 32'd4);
    chk("brst_pc", pc_o, 32'd4);
    chk("brst_valid", {31'b0, valid_o}, 32'd0);

    last_ipc = 32'hFFFF_FFFF;
    hit_end  = 1'b0;
    for (int i = 0; i < 40 && !hit_end; i++) begin
      step(0, 0, 0, 0);
      if (valid_o) last_ipc = inst_pc_o;
      hit_end = done_o;
    end
    chk("end_reached", {31'b0, hit_end}, 32'd1);
    chk("end_last_ipc", last_ipc, 32'd64);
    chk("end_valid", {31'b0, valid_o}, 32'd0);
    chk("end_pc", pc_o, 32'd68);
    step(0, 0, 0, 0);
    chk("end_hold_pc", pc_o, 32'd68);

    step(0, 0, 1, 32'd0);
    chk("end_br_done", {31'b0, done_o}, 32'd0);
    chk("end_br_pc", pc_o, 32'd0);

    step(0, 0, 1, 32'h100);
    chk("oor_done", {31'b0, done_o}, 32'd1);
    step(0, 0, 0, 0);
    chk("oor_valid", {31'b0, valid_o}, 32'd0);
    step(0, 0, 1, 32'hFFFF_FFFE);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_done", {31'b0, done_o}, 32'd1);
    step(0, 0, 1, 32'd64);
    chk("edge_done", {31'b0, done_o}, 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'd65);
    chk("edge65_pc", pc_o, 32'd64);
    step(0, 0, 1, 32'd68);
    step(1, 1, 0, 0);
    chk("rst_end_pc", pc_o, 32'd0);
    chk("rst_end_done", {31'b0, done_o}, 32'd0);
    chk("rst_end_valid", {31'b0, valid_o}, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      bit          r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 20);
      b = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 80));
      step(r, s, b, t);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that drives the byte address into the instruction ROM (`code_memory`) and consumes the 32-bit word it returns.
- Owns the architectural PC and the IF/ID pipeline register.
- Handles stall, taken-branch redirect/flush and end-of-program detection.
- Downstream decode sees a registered instruction, its address, its ARM-visible PC (+8) and a valid bit.

Parameters:
- RESET_PC, 0, byte address loaded into PC on reset.
- MEM_BYTES, 68, size of the code ROM in bytes. A fetch needs pc+3 < MEM_BYTES.
- NOP_INST, 32'hE1A00000, word injected into IF/ID on reset, flush or end (mov r0,r0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  hold PC and IF/ID register this cycle.
- branch_i  input  1  taken branch resolved downstream; redirect this cycle.
- branch_target_i  input  32  byte target of taken branch.
- inst_i  input  32  word returned combinationally by code ROM for pc_o.
- pc_o  output  32  fetch byte address to code ROM (= PC register).
- inst_o  output  32  IF/ID instruction.
- inst_pc_o  output  32  byte address of inst_o.
- pc_plus8_o  output  32  inst_pc_o + 8 (ARM PC-read value), combinational from inst_pc_o.
- valid_o  output  1  inst_o is a real fetched instruction.
- done_o  output  1  fetch has run off the end of ROM (state END).

Behaviour:
- ROM read is combinational: inst_i is valid in the same cycle as pc_o. Fetch-to-IF/ID latency is one clock.
- States: RUN, END. done_o = (state == END).
- On reset (priority 1):
  - PC <= RESET_PC, state <= RUN.
  - inst_o <= NOP_INST, inst_pc_o <= 0, valid_o <= 0.
  - pc_plus8_o = 8.
- branch_i (priority 2, overrides stall_i and END):
  - PC <= {branch_target_i[31:2], 2'b00}; low two bits are ignored.
  - inst_o <= NOP_INST, valid_o <= 0. inst_pc_o holds its value. This is the flush of the wrong-path word.
  - state <= RUN if aligned target + 3 < MEM_BYTES, else END.
- stall_i (priority 3): PC, inst_o, inst_pc_o, valid_o and state all hold. pc_o therefore stays stable.
- RUN, no stall, no branch:
  - If PC + 3 < MEM_BYTES: inst_o <= inst_i, inst_pc_o <= PC, valid_o <= 1, PC <= PC + 4.
  - Else: state <= END, inst_o <= NOP_INST, valid_o <= 0, PC holds.
- END, no branch: PC holds, valid_o <= 0, inst_o <= NOP_INST. Leave END only via branch_i or reset.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32. This is irrelevant in range, because END catches the overrun first.
- Range compare uses PC + 3 computed at 33 bits, so no false in-range result on wrap.
- Reset asserted mid-stall or mid-branch: reset wins, and the state listed above applies on the next edge.
- branch_i and stall_i together: branch taken, flush applied, stall ignored for that cycle.
- pc_o never carries an unaligned value.

Test Plan:
- Reset, then 3 free-running clocks:
  - pc_o sequence is 0, 4, 8, 12.
  - inst_pc_o is 0, 0, 4, 8.
  - valid_o goes 0, then 1 from the second edge.
  - pc_plus8_o = inst_pc_o + 8.
- Stall asserted 2 cycles at pc_o=8: pc_o stays 8, inst_o/inst_pc_o/valid_o frozen. Release: pc_o=12 next edge, inst_pc_o=8.
- branch_i=1 with target 0x2F at pc_o=20:
  - Next edge: pc_o=0x2C, valid_o=0, inst_o=E1A00000.
  - Following edge: inst_pc_o=0x2C, valid_o=1.
- Branch and stall in the same cycle, target 4: branch wins. pc_o=4, valid_o=0.
- Free-run to the end with MEM_BYTES=68:
  - Last valid inst_pc_o=64.
  - Next edge: done_o=1, valid_o=0, pc_o holds 68.
  - Then branch to 0: done_o=0, pc_o=0.
- Branch to 0x100 (out of range): done_o=1 next edge, valid_o stays 0. Reset mid-END: pc_o=0, done_o=0, valid_o=0.
